// File: rtl/vga_plot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vga_plot_arbiter_pkg
//   Definitions shared by the plot arbiter and by the pixel producers that
//   feed it (clear-screen, circuit and text drawers).
//   - Pixel field widths for the 160x120, 3-bit colour VGA adapter.
//   - Default visible-area bounds.
//   - Arbiter FSM state encoding.
//   - Pixel record type and an in-range helper.
// -----------------------------------------------------------------------------
package vga_plot_arbiter_pkg;

    // Pixel field widths expected by the VGA adapter.
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    // Default visible area; anything at or beyond these is clipped.
    localparam int X_MAX_DEF = 160;
    localparam int Y_MAX_DEF = 120;

    // Width of the per-grant stall counter.
    localparam int STALL_W = 8;

    // Arbiter states: IDLE holds no grant, OWNED holds exactly one.
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_OWNED = 1'b1;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

    // True when the pixel lies inside the visible area.
    function automatic logic pixelInRange(input logic [X_W-1:0] x,
                                          input logic [Y_W-1:0] y,
                                          input int xMax,
                                          input int yMax);
        return (int'(x) < xMax) && (int'(y) < yMax);
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//   Purely combinational round-robin selector. Scans the request vector
//   starting at rrPtr and wrapping around; the first set bit wins.
//   Ports:
//     req       in  N_REQ  request bits, bit i = requester i
//     rrPtr     in  PTR_W  index that has highest priority this round
//     winner    out N_REQ  one-hot winner, all-zero when req is all-zero
//     winnerIdx out PTR_W  binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rrPtr,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] winnerIdx
);

    logic found;
    int   idx;

    always_comb begin
        winner    = '0;
        winnerIdx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // Offset from the pointer, wrapped into 0..N_REQ-1.
            idx = int'(rrPtr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                found          = 1'b1;
                winner[idx]    = 1'b1;
                winnerIdx      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// vga_plot_arbiter
//   Shares the single VGA adapter write port between several pixel
//   producers. A producer is granted the port for a whole burst, ended by a
//   pixel flagged with last. Grants are handed out round-robin. A producer
//   that holds the grant but stops supplying pixels for TIMEOUT cycles loses
//   it. Pixels outside the visible area are dropped and flagged.
//
//   Ports:
//     clk            in   single clock, rising edge
//     program_reset  in   synchronous active-high reset
//     req            in   N_REQ    pixel-valid per requester
//     last           in   N_REQ    pixel ends the burst, per requester
//     req_x          in   8*N_REQ  packed x coordinates
//     req_y          in   7*N_REQ  packed y coordinates
//     req_colour     in   3*N_REQ  packed colours
//     grant          out  N_REQ    one-hot owner, zero when idle
//     vga_x/y/colour out  8/7/3    registered pixel for the adapter
//     vga_plot       out  1        adapter write strobe, one cycle per pixel
//     busy           out  1        any grant held
//     timeout_err    out  1        sticky: a grant was force-released
//     clip_err       out  1        sticky: an out-of-range pixel was dropped
// -----------------------------------------------------------------------------
module vga_plot_arbiter
    import vga_plot_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 255,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MAX   = Y_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 program_reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     last,
    input  logic [X_W*N_REQ-1:0] req_x,
    input  logic [Y_W*N_REQ-1:0] req_y,
    input  logic [C_W*N_REQ-1:0] req_colour,
    output logic [N_REQ-1:0]     grant,
    output logic [X_W-1:0]       vga_x,
    output logic [Y_W-1:0]       vga_y,
    output logic [C_W-1:0]       vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 clip_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic               state;
    logic [PTR_W-1:0]   rrPtr;
    logic [PTR_W-1:0]   grantIdx;
    logic [STALL_W-1:0] stallCnt;

    logic [N_REQ-1:0]   pickOneHot;
    logic [PTR_W-1:0]   pickIdx;
    logic [PTR_W-1:0]   rrPtrNext;

    pixel_t             selPix;
    logic               selReq;
    logic               selLast;
    logic               selInRange;
    logic               stallExpired;

    // ------------------------------------------------------------------
    // Winner selection for the next grant.
    // ------------------------------------------------------------------
    rr_priority_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) uPicker (
        .req       (req),
        .rrPtr     (rrPtr),
        .winner    (pickOneHot),
        .winnerIdx (pickIdx)
    );

    // Next round starts just after the winner so it goes to the back.
    assign rrPtrNext = (pickIdx == PTR_W'(N_REQ - 1)) ? '0 : pickIdx + 1'b1;

    // ------------------------------------------------------------------
    // Pixel path from the current owner. Only meaningful while OWNED;
    // requests from everybody else are never looked at here.
    // ------------------------------------------------------------------
    always_comb begin
        selReq        = req[grantIdx];
        selLast       = last[grantIdx];
        selPix.x      = req_x[int'(grantIdx)*X_W +: X_W];
        selPix.y      = req_y[int'(grantIdx)*Y_W +: Y_W];
        selPix.colour = req_colour[int'(grantIdx)*C_W +: C_W];
        selInRange    = pixelInRange(selPix.x, selPix.y, X_MAX, Y_MAX);
    end

    // This stall cycle is the TIMEOUT-th consecutive one: release now.
    assign stallExpired = (stallCnt == STALL_W'(TIMEOUT - 1));

    assign busy = |grant;

    // ------------------------------------------------------------------
    // Arbitration FSM and pixel output register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (program_reset) begin
            // Reset wins over any pixel presented this cycle, so an
            // interrupted burst never reaches the adapter.
            state       <= ST_IDLE;
            grant       <= '0;
            grantIdx    <= '0;
            rrPtr       <= '0;
            stallCnt    <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            timeout_err <= 1'b0;
            clip_err    <= 1'b0;
        end else begin
            // Strobe is a single-cycle pulse per accepted pixel.
            vga_plot <= 1'b0;

            if (state == ST_IDLE) begin
                if (|req) begin
                    state    <= ST_OWNED;
                    grant    <= pickOneHot;
                    grantIdx <= pickIdx;
                    rrPtr    <= rrPtrNext;
                    stallCnt <= '0;
                end
            end else begin
                if (selReq) begin
                    stallCnt <= '0;
                    if (selInRange) begin
                        vga_x      <= selPix.x;
                        vga_y      <= selPix.y;
                        vga_colour <= selPix.colour;
                        vga_plot   <= 1'b1;
                    end else begin
                        // Dropped, but the burst carries on.
                        clip_err <= 1'b1;
                    end
                    if (selLast) begin
                        // Going through IDLE for one cycle gives every
                        // requester a fair look at the next round.
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end else if (stallExpired) begin
                    state       <= ST_IDLE;
                    grant       <= '0;
                    stallCnt    <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    stallCnt <= stallCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_plot_arbiter
//   Directed checks of the plot arbiter with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge; outputs are examined at
//   that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_vga_plot_arbiter;

    localparam int N_REQ = 3;

    logic             clk;
    logic             program_reset;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] last;
    logic [8*N_REQ-1:0] req_x;
    logic [7*N_REQ-1:0] req_y;
    logic [3*N_REQ-1:0] req_colour;
    logic [N_REQ-1:0] grant;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             vga_plot;
    logic             busy;
    logic             timeout_err;
    logic             clip_err;

    int nChecks = 0;
    int nErrors = 0;

    vga_plot_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (255),
        .X_MAX   (160),
        .Y_MAX   (120)
    ) dut (
        .clk           (clk),
        .program_reset (program_reset),
        .req           (req),
        .last          (last),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_colour    (req_colour),
        .grant         (grant),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .clip_err      (clip_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setPix(input int i, input logic [7:0] x, input logic [6:0] y,
                          input logic [2:0] c, input logic isLast);
        req_x[8*i +: 8]      = x;
        req_y[7*i +: 7]      = y;
        req_colour[3*i +: 3] = c;
        last[i]              = isLast;
    endtask

    task automatic doReset();
        program_reset = 1'b1;
        req           = '0;
        last          = '0;
        tick();
        program_reset = 1'b0;
    endtask

    // Safety net: the sequence below is a fixed number of cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        program_reset = 1'b0;
        req        = '0;
        last       = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;

        // ---------------- reset state ----------------
        doReset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_plot",  32'(vga_plot), 32'h0);
        chk("rst_x",     32'(vga_x), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_terr",  32'(timeout_err), 32'h0);
        chk("rst_cerr",  32'(clip_err), 32'h0);

        // ---------------- single 3-pixel burst from requester 1 ----------------
        setPix(1, 8'd10, 7'd20, 3'd4, 1'b0);
        req = 3'b010;
        tick();
        chk("b1_grant", 32'(grant), 32'b010);
        chk("b1_busy",  32'(busy), 32'h1);
        chk("b1_noplot", 32'(vga_plot), 32'h0);
        tick();
        chk("b1_p0_plot", 32'(vga_plot), 32'h1);
        chk("b1_p0_xyc", {vga_x, vga_y, vga_colour}, {8'd10, 7'd20, 3'd4});
        setPix(1, 8'd11, 7'd20, 3'd4, 1'b0);
        tick();
        chk("b1_p1_plot", 32'(vga_plot), 32'h1);
        chk("b1_p1_x",    32'(vga_x), 32'd11);
        setPix(1, 8'd12, 7'd20, 3'd4, 1'b1);
        tick();
        chk("b1_p2_plot", 32'(vga_plot), 32'h1);
        chk("b1_p2_xyc", {vga_x, vga_y, vga_colour}, {8'd12, 7'd20, 3'd4});
        chk("b1_release", 32'(grant), 32'b000);
        req = '0;
        tick();
        chk("b1_after_plot", 32'(vga_plot), 32'h0);
        chk("b1_hold_x",     32'(vga_x), 32'd12);
        chk("b1_idle_busy",  32'(busy), 32'h0);

        // ---------------- round robin with all requesting ----------------
        doReset();
        setPix(0, 8'd1, 7'd1, 3'd1, 1'b1);
        setPix(1, 8'd2, 7'd2, 3'd2, 1'b1);
        setPix(2, 8'd3, 7'd3, 3'd3, 1'b1);
        req = 3'b111;
        tick(); chk("rr_g0", 32'(grant), 32'b001);
        tick(); chk("rr_r0", 32'(grant), 32'b000);
        chk("rr_x0", 32'(vga_x), 32'd1);
        tick(); chk("rr_g1", 32'(grant), 32'b010);
        tick(); chk("rr_r1", 32'(grant), 32'b000);
        chk("rr_x1", 32'(vga_x), 32'd2);
        tick(); chk("rr_g2", 32'(grant), 32'b100);
        tick(); chk("rr_r2", 32'(grant), 32'b000);
        chk("rr_x2", 32'(vga_x), 32'd3);
        tick(); chk("rr_g3", 32'(grant), 32'b001);
        req = '0;

        // ---------------- stall timeout ----------------
        doReset();
        setPix(0, 8'd5, 7'd5, 3'd1, 1'b0);
        setPix(2, 8'd6, 7'd6, 3'd2, 1'b1);
        req = 3'b101;
        tick();
        chk("to_grant", 32'(grant), 32'b001);
        req = 3'b100;
        for (int i = 0; i < 254; i++) tick();
        chk("to_held254", 32'(grant), 32'b001);
        chk("to_noerr254", 32'(timeout_err), 32'h0);
        tick();
        chk("to_release", 32'(grant), 32'b000);
        chk("to_err", 32'(timeout_err), 32'h1);
        tick();
        chk("to_next_grant", 32'(grant), 32'b100);
        chk("to_err_sticky", 32'(timeout_err), 32'h1);
        req = '0;

        // ---------------- clipping ----------------
        doReset();
        setPix(0, 8'd160, 7'd5, 3'd1, 1'b0);
        req = 3'b001;
        tick();
        chk("clip_grant", 32'(grant), 32'b001);
        tick();
        chk("clip_noplot", 32'(vga_plot), 32'h0);
        chk("clip_err", 32'(clip_err), 32'h1);
        chk("clip_held", 32'(grant), 32'b001);
        setPix(0, 8'd159, 7'd119, 3'd7, 1'b1);
        tick();
        chk("clip_edge_plot", 32'(vga_plot), 32'h1);
        chk("clip_edge_xyc", {vga_x, vga_y, vga_colour}, {8'd159, 7'd119, 3'd7});
        chk("clip_release", 32'(grant), 32'b000);
        req = '0;

        // ---------------- reset mid-burst ----------------
        doReset();
        setPix(1, 8'd40, 7'd30, 3'd5, 1'b0);
        req = 3'b010;
        tick();
        for (int i = 0; i < 4; i++) begin
            setPix(1, 8'(40 + i), 7'd30, 3'd5, 1'b0);
            tick();
        end
        chk("mid_plotting", 32'(vga_plot), 32'h1);
        chk("mid_x", 32'(vga_x), 32'd43);
        setPix(1, 8'd44, 7'd30, 3'd5, 1'b0);
        program_reset = 1'b1;
        tick();
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_plot",  32'(vga_plot), 32'h0);
        chk("mid_rst_xyc",   {vga_x, vga_y, vga_colour}, 18'h0);
        chk("mid_rst_busy",  32'(busy), 32'h0);
        program_reset = 1'b0;
        req = '0;
        tick();
        chk("mid_post_plot", 32'(vga_plot), 32'h0);
        tick();
        chk("mid_post_plot2", 32'(vga_plot), 32'h0);

        // ---------------- re-grant after last ----------------
        doReset();
        setPix(0, 8'd7, 7'd8, 3'd2, 1'b1);
        setPix(2, 8'd9, 7'd9, 3'd3, 1'b0);
        req = 3'b001;
        tick();
        chk("rg_grant0", 32'(grant), 32'b001);
        req = 3'b101;
        tick();
        chk("rg_idle", 32'(grant), 32'b000);
        chk("rg_plot", 32'(vga_plot), 32'h1);
        tick();
        chk("rg_grant2", 32'(grant), 32'b100);
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
